// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder with a start/ready/done handshake.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] a_q, a_n;
    logic [WIDTH-1:0] b_q, b_n;
    logic [WIDTH-1:0] r_q, r_n;
    logic [WIDTH-1:0] sum_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic             c_q, c_n;
    logic             sub_q, sub_n;
    logic             carry_n;
    logic             sub_in;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    // One bit slice: two cascaded half adders plus the registered carry.
    logic             b_bit, h1, s_bit, c_out;
    logic [WIDTH-1:0] r_shift;

    always_comb begin
        b_bit   = b_q[0] ^ sub_q;
        h1      = a_q[0] ^ b_bit;
        s_bit   = h1 ^ c_q;
        c_out   = (a_q[0] & b_bit) | (h1 & c_q);
        r_shift = WIDTH'({s_bit, r_q} >> 1);
    end

    // Next-state and datapath control.
    always_comb begin
        state_n = state;
        a_n     = a_q;
        b_n     = b_q;
        r_n     = r_q;
        c_n     = c_q;
        cnt_n   = cnt_q;
        sub_n   = sub_q;
        sum_n   = sum;
        carry_n = carry;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    a_n     = opa;
                    b_n     = opb;
                    r_n     = '0;
                    c_n     = sub_in;
                    sub_n   = sub_in;
                    cnt_n   = '0;
                    state_n = RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                a_n   = a_q >> 1;
                b_n   = b_q >> 1;
                r_n   = r_shift;
                c_n   = c_out;
                cnt_n = CW'(cnt_q + 1'b1);
                if (cnt_q == LAST) begin
                    sum_n   = r_shift;
                    carry_n = c_out;
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            r_q   <= '0;
            c_q   <= 1'b0;
            cnt_q <= '0;
            sub_q <= 1'b0;
            sum   <= '0;
            carry <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
            ready <= 1'b1;
        end else begin
            state <= state_n;
            a_q   <= a_n;
            b_q   <= b_n;
            r_q   <= r_n;
            c_q   <= c_n;
            cnt_q <= cnt_n;
            sub_q <= sub_n;
            sum   <= sum_n;
            carry <= carry_n;
            done  <= (state_n == DONE);
            busy  <= (state_n == RUN);
            ready <= (state_n != RUN);
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 main instance plus a WIDTH=1 instance.
// Subtract vectors are exercised when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] opa = '0;
    logic [W-1:0] opb = '0;
    logic         sub_r = 1'b0;
    logic         ready, busy, done, carry;
    logic [W-1:0] sum;

    logic         s1_start = 1'b0;
    logic         s1_a = 1'b0;
    logic         s1_b = 1'b0;
    logic         s1_ready, s1_busy, s1_done, s1_sum, s1_carry;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .opa   (opa),
        .opb   (opb),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub_r),
`endif
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (s1_start),
        .opa   (s1_a),
        .opb   (s1_b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (1'b0),
`endif
        .ready (s1_ready),
        .busy  (s1_busy),
        .done  (s1_done),
        .sum   (s1_sum),
        .carry (s1_carry)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop the scoreboard on every Done pulse; watch handshake invariants.
    always @(negedge clk) begin
        if (!rst) begin
            if (ready !== !busy) chk("ready_is_not_busy", 32'(ready), 32'(!busy));
            if (done) begin
                exp_t e;
                done_cnt++;
                chk("done_busy_exclusive", 32'(busy), 32'd0);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending result");
                end else begin
                    e = q.pop_front();
                    chk("sum", 32'(sum), 32'(e.s));
                    chk("carry", 32'(carry), 32'(e.c));
                end
            end
        end
    end

    // One operation; optionally re-pulse Start while busy with different operands.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sb,
                          input logic [W-1:0] es, input logic ec, input bit poke);
        logic [W-1:0] old_sum;
        int n;
        old_sum = sum;
        @(posedge clk); #1;
        opa = a; opb = b; sub_r = sb; start = 1'b1;
        q.push_back({es, ec});
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == 3 && poke) begin
                opa = 8'hAA; opb = 8'h55; start = 1'b1;
            end
            if (n == 4) begin
                start = 1'b0;
                if (!done) chk("sum_held_while_busy", 32'(sum), 32'(old_sum));
            end
        end
        chk("latency", 32'(n), 32'(W));
    endtask

    initial begin
        int n, m, dc;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst1_ready", 32'(s1_ready), 32'd1);
        chk("rst1_sum", 32'(s1_sum), 32'd0);

        run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1);
        run_op(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0);

        // Reset at edge 4 of a run aborts it without Done
        @(posedge clk); #1;
        opa = 8'h80; opb = 8'h80; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        dc = done_cnt;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_carry", 32'(carry), 32'd0);
        repeat (12) @(posedge clk);
        #1 chk("abort_no_done", 32'(done_cnt), 32'(dc));

        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

        // Start held through DONE: back-to-back results, Done pulses W+1 apart
        @(posedge clk); #1;
        opa = 8'h0F; opb = 8'h01; sub_r = 1'b0; start = 1'b1;
        q.push_back({8'h10, 1'b0});
        q.push_back({8'h10, 1'b0});
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_first_latency", 32'(n), 32'(W + 1));
        m = 0;
        do begin
            @(posedge clk); #1;
            m++;
            if (m == 1) begin
                start = 1'b0;
                chk("b2b_restart_busy", 32'(busy), 32'd1);
            end
        end while (!done && m < 40);
        chk("b2b_spacing", 32'(m), 32'(W + 1));

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0);
        run_op(8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 1'b0);
        run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
`endif

        // WIDTH=1 instance: 1+1
        @(posedge clk); #1;
        s1_a = 1'b1; s1_b = 1'b1; s1_start = 1'b1;
        @(posedge clk); #1;
        s1_start = 1'b0;
        n = 0;
        while (!s1_done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("w1_latency", 32'(n), 32'd1);
        chk("w1_sum", 32'(s1_sum), 32'd0);
        chk("w1_carry", 32'(s1_carry), 32'd1);
        chk("w1_busy_at_done", 32'(s1_busy), 32'd0);

        repeat (4) @(posedge clk);
        #1 chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
